// File: rtl/fixed_div.sv
// ---------------------------------------------------------------------------
// fixed_div
//
// Sequential signed fixed-point divider: quotient = dividend / divisor, with
// operands and result all in two's-complement Q(DATA_WIDTH-FRAC).FRAC format.
// A restoring radix-2 loop produces one quotient bit per cycle over
// N = DATA_WIDTH + FRAC iterations. The magnitude is truncated, so the result
// rounds toward zero, and it saturates to the representable range.
// One division is in flight at a time.
//
// Parameters
//   DATA_WIDTH  total operand/result width (two's complement)
//   FRAC        number of fractional bits (must be >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   dividend   signed numerator, sampled on the accept edge
//   divisor    signed denominator, sampled on the accept edge
//   out_valid  quotient valid; held until out_ready
//   out_ready  downstream accepts the quotient
//   quotient   signed saturated result
//   div_zero   result came from a zero divisor; valid with out_valid
// ---------------------------------------------------------------------------
module fixed_div #(
    parameter int DATA_WIDTH = 20,
    parameter int FRAC       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_zero
);

    localparam int DW = DATA_WIDTH;
    localparam int N  = DATA_WIDTH + FRAC;
    localparam int CW = $clog2(N);

    localparam logic [DW-1:0] ONE      = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [DW-1:0] QMAX     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] QMIN     = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [N-1:0]    num_q;       // numerator bits, consumed MSB first
    logic [N-1:0]    mag_q;       // unsigned quotient magnitude
    logic [DW-1:0]   dvs_q;       // |divisor|
    logic [DW-1:0]   rem_q;       // partial remainder, always < |divisor|
    logic [CW-1:0]   cnt_q;
    logic            sign_q;      // result sign
    logic            neg_dvd_q;   // dividend sign, selects zero-divide limit
    logic            zero_q;      // divisor was zero
    logic            out_valid_q;
    logic [DW-1:0]   quot_q;
    logic            div_zero_q;

    // Operand magnitudes. An unsigned DW-bit result holds |-2^(DW-1)| exactly.
    logic [DW-1:0] dvd_abs;
    logic [DW-1:0] dvs_abs;

    always_comb begin
        dvd_abs = dividend[DW-1] ? ((~dividend) + ONE) : dividend;
        dvs_abs = divisor[DW-1]  ? ((~divisor)  + ONE) : divisor;
    end

    // One restoring iteration. The shifted remainder needs DW+1 bits since
    // rem_q may be as large as |divisor|-1 before doubling.
    logic [DW:0]   rem_sh;
    logic          q_bit;
    logic [DW-1:0] rem_d;
    logic [N-1:0]  mag_d;

    always_comb begin
        rem_sh = {rem_q, num_q[N-1]};
        q_bit  = (rem_sh >= {1'b0, dvs_q});
        rem_d  = q_bit ? DW'(rem_sh - {1'b0, dvs_q}) : rem_sh[DW-1:0];
        mag_d  = {mag_q[N-2:0], q_bit};
    end

    // Sign application and saturation. A negative result may reach exactly
    // 2^(DW-1) in magnitude (maps to QMIN); a positive one only QMAX.
    logic          pos_over;
    logic          neg_over;
    logic [DW-1:0] neg_mag;
    logic [DW-1:0] quot_d;

    always_comb begin
        pos_over = |mag_q[N-1:DW-1];
        neg_over = (|mag_q[N-1:DW]) | (mag_q[DW-1] & (|mag_q[DW-2:0]));
        neg_mag  = (~mag_q[DW-1:0]) + ONE;
        quot_d   = '0;
        if (zero_q) begin
            quot_d = neg_dvd_q ? QMIN : QMAX;
        end else if (!sign_q) begin
            quot_d = pos_over ? QMAX : mag_q[DW-1:0];
        end else begin
            quot_d = neg_over ? QMIN : neg_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            mag_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            neg_dvd_q   <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        num_q     <= {dvd_abs, {FRAC{1'b0}}};
                        mag_q     <= '0;
                        rem_q     <= '0;
                        dvs_q     <= dvs_abs;
                        sign_q    <= dividend[DW-1] ^ divisor[DW-1];
                        neg_dvd_q <= dividend[DW-1];
                        zero_q    <= (divisor == '0);
                        cnt_q     <= CNT_LAST;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    num_q <= num_q << 1;
                    rem_q <= rem_d;
                    mag_q <= mag_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_FIN: begin
                    quot_q      <= quot_d;
                    div_zero_q  <= zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Depends only on state and rst, never on in_valid.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_fixed_div.sv
module tb_fixed_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] dividend = '0;
    logic [19:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] quotient;
    logic        div_zero;

    int tests = 0;
    int fails = 0;

    fixed_div #(.DATA_WIDTH(20), .FRAC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] a;
        logic [19:0] b;
        logic [19:0] q;
        logic        z;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive operands at the falling edge, accept on the next rising edge.
    task automatic do_accept(input logic [19:0] a, input logic [19:0] b);
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("in_ready_busy", {31'b0, in_ready}, 32'd0);
    endtask

    // Edges after the accept edge until out_valid is seen; bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    int lat;
    int seen;

    initial begin
        vecs[0]  = '{20'h30000, 20'h20000, 20'h18000, 1'b0}; //  3.0 /  2.0
        vecs[1]  = '{20'hF0000, 20'h30000, 20'hFAAAB, 1'b0}; // -1.0 /  3.0
        vecs[2]  = '{20'h10000, 20'hD0000, 20'hFAAAB, 1'b0}; //  1.0 / -3.0
        vecs[3]  = '{20'h70000, 20'h04000, 20'h7FFFF, 1'b0}; //  7.0 / 0.25 sat
        vecs[4]  = '{20'h80000, 20'h08000, 20'h80000, 1'b0}; // -8.0 / 0.5  sat
        vecs[5]  = '{20'h80000, 20'hF0000, 20'h7FFFF, 1'b0}; // -8.0 / -1.0 sat
        vecs[6]  = '{20'h80000, 20'h10000, 20'h80000, 1'b0}; // -8.0 / 1.0 exact
        vecs[7]  = '{20'h10000, 20'h00000, 20'h7FFFF, 1'b1}; //  1.0 / 0
        vecs[8]  = '{20'hF0000, 20'h00000, 20'h80000, 1'b1}; // -1.0 / 0
        vecs[9]  = '{20'h00000, 20'h00000, 20'h7FFFF, 1'b1}; //  0 / 0
        vecs[10] = '{20'hF0000, 20'hF0000, 20'h10000, 1'b0}; // -1.0 / -1.0
        vecs[11] = '{20'h00001, 20'h10000, 20'h00001, 1'b0}; //  1 LSB / 1.0
        vecs[12] = '{20'hFFFFF, 20'h20000, 20'h00000, 1'b0}; // -1 LSB / 2.0 -> 0
        vecs[13] = '{20'h7FFFF, 20'h7FFFF, 20'h10000, 1'b0}; //  x / x
        vecs[14] = '{20'h40000, 20'hC0000, 20'hF0000, 1'b0}; //  4.0 / -4.0

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_quotient", {12'b0, quotient}, 32'h0);
        check("rst_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Table vectors, out_ready held high throughout
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            do_accept(vecs[i].a, vecs[i].b);
            wait_result(lat);
            check($sformatf("latency[%0d]", i), lat, 32'd37);
            check($sformatf("quotient[%0d]", i), {12'b0, quotient}, {12'b0, vecs[i].q});
            check($sformatf("div_zero[%0d]", i), {31'b0, div_zero}, {31'b0, vecs[i].z});
            @(posedge clk);
            #1;
            check($sformatf("handshake_valid[%0d]", i), {31'b0, out_valid}, 32'd0);
            check($sformatf("handshake_ready[%0d]", i), {31'b0, in_ready}, 32'd1);
        end

        // Backpressure plus an ignored in_valid pulse during CALC
        out_ready = 1'b0;
        do_accept(20'h30000, 20'h20000);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) begin
                in_valid = 1'b1;
                dividend = 20'h70000;
                divisor  = 20'h00000;
            end else if (lat == 4) begin
                in_valid = 1'b0;
            end
            if (out_valid) break;
        end
        check("bp_latency", lat, 32'd37);
        check("bp_quotient", {12'b0, quotient}, 32'h18000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_quotient", {12'b0, quotient}, 32'h18000);
            check("bp_hold_div_zero", {31'b0, div_zero}, 32'd0);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of CALC
        do_accept(20'h30000, 20'h20000);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_quotient", {12'b0, quotient}, 32'h0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", {31'b0, in_ready}, 32'd1);
        seen = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 32'd0);

        do_accept(20'h30000, 20'h20000);
        wait_result(lat);
        check("fresh_latency", lat, 32'd37);
        check("fresh_quotient", {12'b0, quotient}, 32'h18000);
        check("fresh_div_zero", {31'b0, div_zero}, 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
